// File: rtl/frogger_tick_gen.sv
// rtl/frogger_tick_gen.sv - multi-channel programmable tick/clock-enable generator
// Optional square outputs are built only when FROGGER_TICK_SQUARE_EN is defined.
module frogger_tick_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 25_000_000
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] square
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] cnt_q;
        logic             tick_q;
        logic             wr_hit;
        logic             at_term;
        logic             fire;

        assign wr_hit  = wr_en && (wr_ch == 4'(c));
        assign at_term = (cnt_q == div_q - CNT_W'(1));
        // A write or a paused/disabled channel always beats terminal count.
        assign fire    = !wr_hit && run && (div_q != '0) && at_term;

        always_ff @(posedge Clk or negedge reset_n) begin
            if (!reset_n) begin
                div_q  <= CNT_W'(DEFAULT_DIV);
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else if (wr_hit) begin
                div_q  <= wr_div;
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else if (!run) begin
                tick_q <= 1'b0;
            end else if (div_q == '0) begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else if (at_term) begin
                cnt_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
                tick_q <= 1'b0;
            end
        end

        assign tick[c] = tick_q;

`ifdef FROGGER_TICK_SQUARE_EN
        logic sq_q;

        always_ff @(posedge Clk or negedge reset_n) begin
            if (!reset_n) begin
                sq_q <= 1'b0;
            end else if (fire) begin
                sq_q <= ~sq_q;
            end
        end

        assign square[c] = sq_q;
`else
        logic unused_fire;
        assign unused_fire = fire;
        assign square[c]   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_frogger_tick_gen.sv
// tb/tb_frogger_tick_gen.sv - randomized self-checking bench for frogger_tick_gen
module tb_frogger_tick_gen;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int DDIV   = 5;
`ifdef FROGGER_TICK_SQUARE_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              run = 1'b0;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_ch = '0;
    logic [CNT_W-1:0]  wr_div = '0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] square;

    int vectors = 0;
    int fails   = 0;

    frogger_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DDIV)) dut (
        .Clk(Clk), .reset_n(reset_n), .run(run), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_div(wr_div), .tick(tick), .square(square)
    );

    always #5 Clk = ~Clk;

    // Reference: countdown of run-high edges remaining until the next tick.
    int                m_rem [NUM_CH];
    int                m_div [NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_sq;
    logic [NUM_CH-1:0] exp_sq;

    assign exp_sq = SQ_EN ? m_sq : '0;

    always @(posedge Clk or negedge reset_n) begin
        int   r;
        int   d;
        logic t;
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_div[c] <= DDIV;
                m_rem[c] <= DDIV;
            end
            m_tick <= '0;
            m_sq   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r = m_rem[c];
                d = m_div[c];
                t = 1'b0;
                if (wr_en && wr_ch == 4'(c)) begin
                    d = int'(wr_div);
                    r = d;
                end else if (run && d != 0) begin
                    r = r - 1;
                    if (r == 0) begin
                        t = 1'b1;
                        r = d;
                        m_sq[c] <= ~m_sq[c];
                    end
                end
                m_rem[c]  <= r;
                m_div[c]  <= d;
                m_tick[c] <= t;
            end
        end
    end

    task automatic cyc(input logic r, input logic we, input int ch, input int dv);
        run    = r;
        wr_en  = we;
        wr_ch  = 4'(ch);
        wr_div = CNT_W'(dv);
        @(negedge Clk);
        wr_en  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        reset_n = 1'b0;
        run     = 1'b0;
        wr_en   = 1'b0;
        repeat (2) @(negedge Clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (tick !== '0 || square !== '0) begin
            fails++;
            $display("FAIL reset: tick=%b square=%b required 00/00", tick, square);
        end
    endtask

    task automatic test_default();
        int n0;
        n0 = 0;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b0, 0, 0);
            n0 += int'(tick[0]);
            vectors++;
            if (tick !== m_tick || square !== exp_sq) begin
                fails++;
                $display("FAIL default cyc%0d: tick=%b sq=%b required %b/%b", k, tick, square, m_tick, exp_sq);
            end
        end
        vectors++;
        if (n0 != 3) begin
            fails++;
            $display("FAIL default_count: ticks=%0d required 3", n0);
        end
    endtask

    task automatic test_write_ch1();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, k == 7, 1, 3);
            vectors++;
            if (tick !== m_tick || square !== exp_sq) begin
                fails++;
                $display("FAIL write_ch1 cyc%0d: tick=%b sq=%b required %b/%b", k, tick, square, m_tick, exp_sq);
            end
        end
    endtask

    task automatic test_run_pause();
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            cyc(!(k >= 3 && k <= 8), 1'b0, 0, 0);
            vectors++;
            if (tick !== m_tick || square !== exp_sq) begin
                fails++;
                $display("FAIL run_pause cyc%0d: tick=%b sq=%b required %b/%b", k, tick, square, m_tick, exp_sq);
            end
        end
    endtask

    task automatic test_div_zero_one();
        do_reset();
        cyc(1'b1, 1'b1, 0, 0);
        for (int k = 1; k <= 50; k++) begin
            cyc(1'b1, 1'b0, 0, 0);
            vectors++;
            if (tick[0] !== 1'b0 || tick !== m_tick) begin
                fails++;
                $display("FAIL div_zero cyc%0d: tick=%b required %b", k, tick, m_tick);
            end
        end
        cyc(1'b1, 1'b1, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 1'b0, 0, 0);
            vectors++;
            if (tick[0] !== 1'b1 || tick !== m_tick || square !== exp_sq) begin
                fails++;
                $display("FAIL div_one cyc%0d: tick=%b sq=%b required %b/%b", k, tick, square, m_tick, exp_sq);
            end
        end
    endtask

    task automatic test_bad_ch_and_term_write();
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, k == 3 || k == 5, k == 3 ? 3 : 0, k == 3 ? 1 : 5);
            vectors++;
            if (tick !== m_tick || square !== exp_sq) begin
                fails++;
                $display("FAIL bad_ch_term cyc%0d: tick=%b sq=%b required %b/%b", k, tick, square, m_tick, exp_sq);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 1; k <= 600; k++) begin
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3), $urandom_range(0, 6));
            vectors++;
            if (tick !== m_tick || square !== exp_sq) begin
                fails++;
                $display("FAIL random cyc%0d: tick=%b sq=%b required %b/%b", k, tick, square, m_tick, exp_sq);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1'b1, 1'b1, 1, 2);
        repeat (6) cyc(1'b1, 1'b0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (tick !== '0 || square !== '0 || m_tick !== '0) begin
            fails++;
            $display("FAIL async_reset: tick=%b sq=%b required 00/00", tick, square);
        end
        @(negedge Clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            cyc(1'b1, 1'b0, 0, 0);
            vectors++;
            if (tick !== m_tick || square !== exp_sq || tick[1] !== (k == 5 || k == 10)) begin
                fails++;
                $display("FAIL after_reset cyc%0d: tick=%b sq=%b required %b/%b", k, tick, square, m_tick, exp_sq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_write_ch1();
        test_run_pause();
        test_div_zero_one();
        test_bad_ch_and_term_write();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/frogger_tick_gen.md
# frogger_tick_gen

Multi-channel, run-time programmable tick generator replacing the fixed 1 Hz divider used for game timing. Each channel divides `Clk` by its own programmable divisor and produces a one-cycle clock-enable pulse, `tick`, plus an optional 50% square wave. Channels pace independent game events (frog timer, lane speeds, blink) without generating derived clocks. All logic runs in the `Clk` domain.

## Interface
- `NUM_CH`, default 4: number of independent channels (1..16).
- `CNT_W`, default 28: divisor and counter width.
- `DEFAULT_DIV`, default 25_000_000: divisor loaded into every channel at reset (1 Hz square at 50 MHz).
- `Clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `run`  in  1: global run; low freezes all channels.
- `wr_en`  in  1: divisor write strobe, one cycle.
- `wr_ch`  in  4: channel index for the write.
- `wr_div`  in  CNT_W: new divisor.
- `tick`  out  NUM_CH: per-channel one-cycle enable pulse, registered.
- `square`  out  NUM_CH: per-channel square wave, registered; toggles on each tick.

## Operation
- Per-channel state: `div[c]` (CNT_W), `cnt[c]` (CNT_W), `tick[c]`, `square[c]`.
- Reset (`reset_n` low, asynchronous) sets:
  - `div[c]` = DEFAULT_DIV.
  - `cnt[c]` = 0.
  - `tick` = 0.
  - `square` = 0.
- Per edge, per channel, priority order:
  1. Write hit (`wr_en` and `wr_ch == c`): `div[c]` <= `wr_div`, `cnt[c]` <= 0, `tick[c]` <= 0, `square[c]` unchanged. A write wins over a simultaneous terminal count, so no tick is issued.
  2. `run` low: `cnt` holds, `tick[c]` <= 0, `square` holds.
  3. `div[c]` == 0: channel disabled. `cnt[c]` <= 0, `tick[c]` <= 0, `square` holds.
  4. `cnt[c]` == `div[c]` − 1 (terminal): `cnt[c]` <= 0, `tick[c]` <= 1, `square[c]` toggles.
  5. Otherwise: `cnt[c]` <= `cnt[c]` + 1, `tick[c]` <= 0.
- Divisor semantics:
  - Tick period is exactly `div` cycles.
  - Square period is 2·`div` cycles.
  - `div` = 1 gives `tick` stuck high while running, and `square` toggles every cycle.
- A write with `wr_ch` ≥ NUM_CH is ignored, with no side effects on any channel.
- Counter compare is unsigned. `cnt` never exceeds `div` − 1, because every divisor change clears `cnt`; there is no wrap-around overflow.
- Channels are fully independent. Only `run` and `reset_n` are shared.

## Timing
- After `reset_n` deasserts with `run` high, the first `tick[c]` is high during the cycle following the `div`-th rising edge. It lasts exactly one cycle and repeats every `div` cycles.
- After a write at edge E, `tick` for the written channel first asserts after edge E + `div_new`.
- Deasserting `run` mid-count preserves phase. On resume, the remaining count continues and the total tick interval equals `div` counted run-high cycles.
- A tick pending on the same edge that `run` falls is suppressed. The count it would have completed is held at `div` − 1 and fires on the first run-high edge.
- Reset asserted mid-operation clears state immediately (asynchronously). `tick` is never high while `reset_n` is low.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- Macro: `FROGGER_TICK_SQUARE_EN`.
- Defined: `square` outputs behave as specified.
- Undefined:
  - The `square` port remains but is tied to 0.
  - The toggle flops are not generated.
  - `tick` behaviour is identical.

## Test plan
Bench parameters are NUM_CH=2, CNT_W=8, DEFAULT_DIV=5.
- Reset release, `run`=1, no writes -> `tick[0]` and `tick[1]` high on cycles 5, 10, 15, each for one cycle. `square` reads 1 after the first tick and 0 after the second.
- Write `wr_ch`=1, `wr_div`=3 at cycle 7 -> `tick[1]` at cycles 10 and 13. `tick[0]` is unaffected (cycles 10, 15). `square[1]` does not toggle on the write itself.
- `run` low for cycles 3–8, then high -> `tick[0]` at cycle 11 (5 run-high cycles), and `square` holds its value during the pause.
- Write `div`=0 to ch0 -> `tick[0]` stays 0 for 50 cycles. Then write 1 -> `tick[0]` is high every cycle and `square[0]` toggles every cycle.
- Write to `wr_ch`=3 -> no change on either channel's tick spacing. Write coinciding with terminal count on ch0 -> no tick that cycle, and the next tick occurs `div` cycles later.
- Assert `reset_n` low asynchronously mid-count -> `tick` and `square` go 0 immediately. After release, the first tick occurs at cycle 5 with divisors restored to 5.
